// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out word serializer with valid and end-of-word pulse
// Define PISO_PARITY_EN to append an even-parity bit after the data bits.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] in,
    output logic             ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR, DONE} state_t;
    logic             par_q;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [CW-1:0]    cnt_q;
    logic             sout_q;
    logic             sout_valid_q;
    logic             done_q;
    logic             first_bit;
    logic             next_bit;

    // shreg always holds the current bit at its output end, so the next bit sits one place in
    always_comb begin
        shreg_d   = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
        next_bit  = MSB_FIRST ? shreg_q[WIDTH-2] : shreg_q[1];
        first_bit = MSB_FIRST ? in[WIDTH-1] : in[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            cnt_q        <= '0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            done_q       <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q        <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (load) begin
                        state_q      <= SHIFT;
                        shreg_q      <= in;
                        cnt_q        <= '0;
                        sout_q       <= first_bit;
                        sout_valid_q <= 1'b1;
`ifdef PISO_PARITY_EN
                        par_q        <= ^in;
`endif
                    end
                end
                SHIFT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) begin
`ifdef PISO_PARITY_EN
                        state_q      <= PAR;
                        sout_q       <= par_q;
`else
                        state_q      <= DONE;
                        sout_q       <= 1'b0;
                        sout_valid_q <= 1'b0;
                        done_q       <= 1'b1;
`endif
                    end else begin
                        shreg_q <= shreg_d;
                        sout_q  <= next_bit;
                    end
                end
`ifdef PISO_PARITY_EN
                PAR: begin
                    state_q      <= DONE;
                    sout_q       <= 1'b0;
                    sout_valid_q <= 1'b0;
                    done_q       <= 1'b1;
                end
`endif
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q      <= IDLE;
                    sout_q       <= 1'b0;
                    sout_valid_q <= 1'b0;
                    done_q       <= 1'b0;
                end
            endcase
        end
    end

    assign ready      = (state_q == IDLE);
    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign done       = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - directed bench for piso_serializer, MSB-first and LSB-first instances
module tb_piso_serializer;

    logic       clk;
    logic       rst;
    logic       load_m, load_l;
    logic [3:0] in_m, in_l;
    logic       ready_m, sout_m, valid_m, done_m;
    logic       ready_l, sout_l, valid_l, done_l;

    bit         sel_msb;
    logic       o_ready, o_sout, o_valid, o_done;
    int         n_cmp;
    int         n_err;
    int         lat;

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .load(load_m), .in(in_m),
        .ready(ready_m), .sout(sout_m), .sout_valid(valid_m), .done(done_m)
    );

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .load(load_l), .in(in_l),
        .ready(ready_l), .sout(sout_l), .sout_valid(valid_l), .done(done_l)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        o_ready = sel_msb ? ready_m : ready_l;
        o_sout  = sel_msb ? sout_m  : sout_l;
        o_valid = sel_msb ? valid_m : valid_l;
        o_done  = sel_msb ? done_m  : done_l;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic l, input logic [3:0] w);
        if (sel_msb) begin
            load_m = l;
            in_m   = w;
        end else begin
            load_l = l;
            in_l   = w;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, o_ready, 1);
        check({tag, "_sout"},  o_sout,  0);
        check({tag, "_valid"}, o_valid, 0);
        check({tag, "_done"},  o_done,  0);
    endtask

    // exp_bits[3] is the first bit expected on sout
    task automatic run_word(input bit msb, input logic [3:0] word, input logic [3:0] exp_bits,
                            input logic exp_par, input bit inject, input bit preload,
                            input logic [3:0] next_word);
        sel_msb = msb;
        drive(1'b1, word);
        #1;
        check("ready_indep_of_load", o_ready, 1);
        step();
        lat = 0;
        drive(1'b0, word);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bit%0d", i), o_sout, exp_bits[3-i]);
            check($sformatf("valid%0d", i), o_valid, 1);
            check($sformatf("busy%0d", i), o_ready, 0);
            check($sformatf("no_early_done%0d", i), o_done, 0);
            drive(inject && (i == 1), 4'hC);
            step();
            lat++;
        end
        drive(1'b0, 4'h0);
`ifdef PISO_PARITY_EN
        check("parity_bit", o_sout, exp_par);
        check("parity_valid", o_valid, 1);
        check("parity_done", o_done, 0);
        step();
        lat++;
`else
        check("par_unused", {31'd0, exp_par}, {31'd0, exp_par ^ 1'b0});
`endif
        check("done_pulse", o_done, 1);
        check("done_valid", o_valid, 0);
        check("done_sout", o_sout, 0);
        check("done_ready", o_ready, 0);
        if (preload) drive(1'b1, next_word);
        step();
        lat++;
`ifdef PISO_PARITY_EN
        check("load_to_ready", lat, 6);
`else
        check("load_to_ready", lat, 5);
`endif
        check_idle_outputs("post_word");
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        sel_msb = 1'b1;
        rst     = 1'b1;
        load_m  = 1'b0;
        load_l  = 1'b0;
        in_m    = 4'h0;
        in_l    = 4'h0;

        // reset takes effect before any clock edge
        #2;
        sel_msb = 1'b1;
        check_idle_outputs("rst_msb");
        sel_msb = 1'b0;
        check_idle_outputs("rst_lsb");
        step();
        step();
        rst = 1'b0;

        // A MSB-first with an ignored load of C mid-word
        run_word(1'b1, 4'hA, 4'b1010, 1'b0, 1'b1, 1'b0, 4'h0);

        // C LSB-first, then 3 with load held through the done cycle
        run_word(1'b0, 4'hC, 4'b0011, 1'b0, 1'b0, 1'b1, 4'h3);
        run_word(1'b0, 4'h3, 4'b1100, 1'b0, 1'b0, 1'b0, 4'h0);

        // abort F after two bits with an unaligned reset
        sel_msb = 1'b1;
        drive(1'b1, 4'hF);
        step();
        drive(1'b0, 4'h0);
        check("abort_bit0", o_sout, 1);
        step();
        check("abort_bit1", o_sout, 1);
        step();
        #3;
        rst = 1'b1;
        #1;
        check_idle_outputs("async_rst");
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("no_done_after_abort%0d", i), o_done, 0);
        end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check($sformatf("abort_quiet%0d", i), o_done, 0);
        end
        run_word(1'b1, 4'h5, 4'b0101, 1'b0, 1'b0, 1'b0, 4'h0);

        // parity cases: F -> 0, 7 -> 1
        run_word(1'b1, 4'hF, 4'b1111, 1'b0, 1'b0, 1'b0, 4'h0);
        run_word(1'b1, 4'h7, 4'b0111, 1'b1, 1'b0, 1'b0, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
